// File: rtl/result_digit_streamer.sv
// result_digit_streamer
//   Converts an 11-bit ALU result into decimal symbols and streams them MSB-first
//   as (num_led, length) pairs for the ledtube display path.
//   An optional minus sign (SIGN_CODE) comes first. Digits follow with leading zeros
//   suppressed. Conversion is a sequential double-dabble that handles one bit per cycle.
//   Optional build macro: STREAMER_MOD1000_EN. When it is defined, non-negative
//   magnitudes >= 1000 are shown modulo 1000.
//
//   Handshake: start is sampled only in IDLE. busy stays high from the accepting edge
//   until the cycle in which done pulses. digit_valid pulses once per symbol, and
//   num_led/length are stable from that pulse until the next symbol. Neither side can
//   stall the stream.
module result_digit_streamer #(
   parameter int unsigned HOLD_CYCLES = 3,
   parameter logic [3:0]  SIGN_CODE   = 4'hA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [10:0] result,
   input  logic        signed_mode,
   output logic        busy,
   output logic        done,
   output logic        digit_valid,
   output logic [3:0]  num_led,
   output logic [2:0]  length
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_EMIT    = 3'd2,
      S_HOLD    = 3'd3,
      S_FIN     = 3'd4
   } state_e;

   localparam int unsigned    HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

   state_e         state_q, state_d;
   logic [10:0]    sh_q, sh_d;        // magnitude bits still to be shifted into the BCD
   logic [15:0]    bcd_q, bcd_d;      // four BCD digits, thousands in [15:12]
   logic           neg_q, neg_d;
   logic [3:0]     cnt_q, cnt_d;      // double-dabble step counter (0..10)
   logic [HW-1:0]  hold_q, hold_d;
   logic [3:0]     led_q, led_d;
   logic [2:0]     len_q, len_d;
   logic           dv_q, dv_d;

   logic [15:0]    disp;              // digits as they are shown
   logic [2:0]     n_dig;             // significant digit count (1..4)
   logic [2:0]     total;             // symbol count including the sign
   logic [2:0]     pos;               // position of the next symbol, counted from the units digit
   logic [3:0]     sym;
   logic           in_neg;
   logic [10:0]    in_mag;

   // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit
   function automatic logic [15:0] dd_step(input logic [15:0] b, input logic in_bit);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return {r[14:0], in_bit};
   endfunction

   // Sign and magnitude of the incoming result. -1024 maps to 1024, which still fits in 11 bits.
   always_comb begin
      in_neg = signed_mode & result[10];
      in_mag = in_neg ? (~result + 11'd1) : result;
   end

`ifdef STREAMER_MOD1000_EN
   // Non-negative values drop the thousands digit. Negative values are shown in full.
   assign disp = neg_q ? bcd_q : {4'h0, bcd_q[11:0]};
`else
   assign disp = bcd_q;
`endif

   // Symbol selection: length counts the symbols already emitted, so it indexes the list
   always_comb begin
      if (disp[15:12] != 4'd0)     n_dig = 3'd4;
      else if (disp[11:8] != 4'd0) n_dig = 3'd3;
      else if (disp[7:4] != 4'd0)  n_dig = 3'd2;
      else                         n_dig = 3'd1;
      total = n_dig + {2'b00, neg_q};
      pos   = total - 3'd1 - len_q;
      sym   = disp[3:0];
      if (neg_q && (pos == n_dig)) begin
         sym = SIGN_CODE;
      end else begin
         case (pos[1:0])
            2'd0:    sym = disp[3:0];
            2'd1:    sym = disp[7:4];
            2'd2:    sym = disp[11:8];
            default: sym = disp[15:12];
         endcase
      end
   end

   // Next-state and datapath updates for the stream FSM
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      led_d   = led_q;
      len_d   = len_q;
      dv_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               neg_d   = in_neg;
               sh_d    = in_mag;
               bcd_d   = 16'd0;
               cnt_d   = 4'd0;
               len_d   = 3'd0;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            bcd_d = dd_step(bcd_q, sh_q[10]);
            sh_d  = {sh_q[9:0], 1'b0};
            if (cnt_q == 4'd10) state_d = S_EMIT;
            else                cnt_d   = cnt_q + 4'd1;
         end
         S_EMIT: begin
            led_d   = sym;
            len_d   = len_q + 3'd1;
            dv_d    = 1'b1;
            hold_d  = '0;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = (len_q == total) ? S_FIN : S_EMIT;
            else                     hold_d  = hold_q + HW'(1);
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any stream in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
         led_q   <= '0;
         len_q   <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         led_q   <= led_d;
         len_q   <= len_d;
         dv_q    <= dv_d;
      end
   end

   // Status decoded from the state register. busy drops in the same cycle that done pulses.
   always_comb begin
      busy        = (state_q != S_IDLE) && (state_q != S_FIN);
      done        = (state_q == S_FIN);
      digit_valid = dv_q;
      num_led     = led_q;
      length      = len_q;
   end

endmodule

// File: tb/tb_result_digit_streamer.sv
// Bench for result_digit_streamer: directed and random streams checked against a
// decimal-arithmetic model of the symbol list and the stream timing.
module tb_result_digit_streamer;

   localparam int unsigned H    = 3;
   localparam int          HP   = 4;      // H + 1: cycles between digit_valid pulses
   localparam int          LAT  = 12;     // accepting edge -> first digit_valid sample
   localparam logic [3:0]  SIGN = 4'hA;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] result = '0;
   logic        signed_mode = 1'b0;
   logic        busy, done, digit_valid;
   logic [3:0]  num_led;
   logic [2:0]  length;

   int checks = 0;
   int failures = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   result_digit_streamer #(.HOLD_CYCLES(H), .SIGN_CODE(SIGN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .result(result),
      .signed_mode(signed_mode), .busy(busy), .done(done),
      .digit_valid(digit_valid), .num_led(num_led), .length(length)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal symbol list computed with integer arithmetic
   function automatic void build_expected(input logic [10:0] res, input logic sm);
      int v, mag;
      bit neg;
      exp_q.delete();
      v = (sm && res[10]) ? int'(res) - 2048 : int'(res);
      neg = (v < 0);
      mag = neg ? -v : v;
`ifdef STREAMER_MOD1000_EN
      if (!neg && mag >= 1000) mag = mag % 1000;
`endif
      do begin
         exp_q.push_front(4'(mag % 10));
         mag = mag / 10;
      end while (mag > 0);
      if (neg) exp_q.push_front(SIGN);
   endfunction

   // Run one full stream and check every cycle. poke adds start pulses while busy.
   task automatic run_stream(input logic [10:0] res, input logic sm, input bit poke);
      int n, done_k, idx;
      bit dv_exp;
      build_expected(res, sm);
      n = exp_q.size();
      done_k = LAT + (n - 1) * HP + int'(H);
      @(negedge clk);
      result = res; signed_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0; result = 11'($urandom); signed_mode = 1'($urandom);
      chk("accept_busy", 16'(busy), 16'd1);
      chk("accept_len", 16'(length), 16'd0);
      chk("accept_dv", 16'(digit_valid), 16'd0);
      for (int k = 1; k <= done_k + 4; k++) begin
         @(negedge clk);
         dv_exp = (k >= LAT) && ((k - LAT) % HP == 0) && ((k - LAT) / HP < n);
         chk($sformatf("dv_k%0d", k), 16'(digit_valid), 16'(dv_exp));
         chk($sformatf("done_k%0d", k), 16'(done), 16'(k == done_k));
         chk($sformatf("busy_k%0d", k), 16'(busy), 16'(k < done_k));
         if (dv_exp) begin
            idx = (k - LAT) / HP;
            chk($sformatf("sym%0d", idx), 16'(num_led), 16'(exp_q[idx]));
            chk($sformatf("len%0d", idx), 16'(length), 16'(idx + 1));
         end
         if (k > done_k) begin
            chk("hold_led", 16'(num_led), 16'(exp_q[n-1]));
            chk("hold_len", 16'(length), 16'(n));
         end
         if (poke) start = (k == 3) || (k == 11) || (k == 14);
      end
      start = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, 16'(busy), 16'd0);
      chk({tag, "_done"}, 16'(done), 16'd0);
      chk({tag, "_dv"}, 16'(digit_valid), 16'd0);
      chk({tag, "_led"}, 16'(num_led), 16'd0);
      chk({tag, "_len"}, 16'(length), 16'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // directed streams
      run_stream(11'd123, 1'b0, 1'b0);
      run_stream(11'd0, 1'b0, 1'b0);
      run_stream(11'h7F9, 1'b1, 1'b0);
      run_stream(11'h400, 1'b1, 1'b0);
      run_stream(11'd1500, 1'b0, 1'b0);
      run_stream(11'd2047, 1'b0, 1'b0);
      run_stream(11'd1000, 1'b0, 1'b0);
      run_stream(11'h7FF, 1'b1, 1'b0);
      run_stream(11'h400, 1'b0, 1'b0);
      run_stream(11'd9, 1'b1, 1'b0);
      run_stream(11'd123, 1'b0, 1'b1);

      // reset during the second hold of a stream aborts it with no done
      @(negedge clk);
      result = 11'd123; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 17; k++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values("abort");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", 16'(done), 16'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("post_abort");
      run_stream(11'd456, 1'b0, 1'b0);

      // random streams
      for (int r = 0; r < 8; r++) begin
         run_stream(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
